cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Instruction-sequencing state machine for the 8-bit RISC CPU.
- Steps every instruction through eight fixed phases: two-byte fetch into the instruction register, decode, execute, write-back.
- Drives the load/read/write strobes of the IR, accumulator, PC, memory and data-bus driver.
- Sits between the clock/enable generator and the datapath registers; consumes the opcode from the IR and the accumulator zero flag.

Parameters:
- OPCODE_W, 3: opcode field width; fixed at 3 for the eight-instruction ISA.
- STATE_W, 4: state register width; holds phases S0..S7 plus HALTED.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  run enable; low freezes the sequence.
- opcode  input  OPCODE_W  IR opcode field; valid from S2 onward.
- zero  input  1  accumulator-zero flag.
- state  output  STATE_W  current phase; debug and bench visibility.
- rd  output  1  memory read strobe.
- wr  output  1  memory write strobe.
- load_ir  output  1  IR byte load.
- inc_pc  output  1  PC increment.
- load_pc  output  1  PC load from IR address field.
- load_acc  output  1  accumulator load.
- datactl_ena  output  1  accumulator-to-bus driver enable.
- halt  output  1  CPU halted.

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111. ALU group = ADD/ANDD/XORR.
- State register is the only sequential element besides the implied halted condition (HALTED state).
- Reset (async, rst_n=0): state=S0. All strobes 0 while rst_n=0; halt=0.
- Strobes are combinational from (state, opcode, zero) and gated by ena. With ena=0, every strobe is 0 and state holds.
- With ena=1, state advances S0->S1->...->S7->S0, one per clock. One instruction = 8 enabled clocks.
- S0: rd, load_ir (high byte).
- S1: rd, load_ir (low byte), inc_pc.
- S2: all strobes 0 (decode slot; opcode now valid).
- S3:
  - HLT: halt=1, no inc_pc; next state HALTED.
  - Otherwise: inc_pc.
- S4:
  - ALU/LDA: rd.
  - STO: datactl_ena.
  - JMP: load_pc.
- S5:
  - ALU/LDA: rd, load_acc.
  - STO: datactl_ena, wr.
  - JMP: load_pc.
- S6:
  - STO: datactl_ena.
  - SKZ with zero=1: inc_pc.
- S7: SKZ with zero=1: inc_pc.
- Any combination not listed above: strobe 0.
- PC accounting: a normal instruction gives 2 inc_pc pulses; a taken SKZ gives 4 (skips the next 2-byte instruction); JMP gives 2 inc_pc plus load_pc, and load_pc has priority in the PC.
- wr is never asserted without datactl_ena in the same cycle. datactl_ena surrounds wr by one cycle on each side.
- HALTED: halt=1 regardless of ena; all other strobes 0; state holds. Exit only via rst_n.
- zero is sampled combinationally in S6/S7 only; changes elsewhere have no effect.
- Reset asserted mid-instruction: immediate return to S0; next instruction starts at the fetch phase.

Optional Feature:
- Macro: CPU_CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - On reaching S0 from S7, the FSM waits in S0 with all strobes 0 until a clock where step=1 and ena=1.
  - The S0 fetch strobes are driven in that cycle, then the instruction runs to completion.
  - The first instruction after reset also waits for step.
- When undefined: no step port; free-running as above.

Decomposition:
- Shared package cpu_pkg holds opcode localparams, state encodings (S0..S7, HALTED) and the ALU-group membership function.
- One natural sub-module: cpu_ctrl_decode, the purely combinational (state, opcode, zero, ena) -> strobe decoder.
- The top module keeps the state register and transition logic.

Test Plan:
- Reset, then LDA, ena=1 -> cycle trace:
  - S0: rd, load_ir.
  - S1: rd, load_ir, inc_pc.
  - S3: inc_pc.
  - S4: rd.
  - S5: rd, load_acc.
  - Back to S0 after 8 clocks.
- STO -> datactl_ena high in S4,S5,S6; wr high only in S5; load_acc never high.
- SKZ with zero=1 -> 4 inc_pc pulses (S1,S3,S6,S7). SKZ with zero=0 -> 2 pulses.
- HLT -> halt=1 from S3, state=HALTED. No strobes for 20 clocks even with ena toggling. rst_n=0 returns to S0 with halt=0.
- ena low for 3 clocks at S4 of an ADD -> state stays S4 and strobes are 0; resumes at S4 with rd=1 when ena returns.
- rst_n pulse asynchronously mid-S5 of JMP -> state=S0 immediately (before next posedge); load_pc never seen after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU controller: opcodes, phase encodings,
// strobe bundle and ALU-group membership.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned STATE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_HLT  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ  = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_ANDD = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XORR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA  = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_e;

  typedef struct packed {
    logic rd;
    logic wr;
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic halt;
  } strobe_t;

  function automatic logic is_alu(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational (state, opcode, zero, ena) -> datapath strobe decoder.
// HALTED asserts halt independent of ena; every other strobe is gated by ena.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_e                state,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  zero,
  input  logic                  ena,
  output strobe_t               strobes_c
);

  logic acc_rd;
  assign acc_rd = is_alu(opcode) || (opcode == OP_LDA);

  always_comb begin
    strobes_c = '0;
    if (state == HALTED) begin
      strobes_c.halt = 1'b1;
    end else if (ena) begin
      case (state)
        S0: begin
          strobes_c.rd      = 1'b1;
          strobes_c.load_ir = 1'b1;
        end
        S1: begin
          strobes_c.rd      = 1'b1;
          strobes_c.load_ir = 1'b1;
          strobes_c.inc_pc  = 1'b1;
        end
        S3: begin
          if (opcode == OP_HLT) strobes_c.halt   = 1'b1;
          else                  strobes_c.inc_pc = 1'b1;
        end
        S4: begin
          if (acc_rd)                strobes_c.rd          = 1'b1;
          else if (opcode == OP_STO) strobes_c.datactl_ena = 1'b1;
          else if (opcode == OP_JMP) strobes_c.load_pc     = 1'b1;
        end
        S5: begin
          if (acc_rd) begin
            strobes_c.rd       = 1'b1;
            strobes_c.load_acc = 1'b1;
          end else if (opcode == OP_STO) begin
            strobes_c.datactl_ena = 1'b1;
            strobes_c.wr          = 1'b1;
          end else if (opcode == OP_JMP) begin
            strobes_c.load_pc = 1'b1;
          end
        end
        // Bus driver stays on one cycle past wr; taken SKZ skips the next instruction.
        S6: begin
          if (opcode == OP_STO)              strobes_c.datactl_ena = 1'b1;
          else if (opcode == OP_SKZ && zero) strobes_c.inc_pc      = 1'b1;
        end
        S7: begin
          if (opcode == OP_SKZ && zero) strobes_c.inc_pc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction-sequencing FSM: eight-phase fetch/decode/execute/write-back cycle.
// Optional single-step gating of the fetch phase under CPU_CTRL_SINGLE_STEP_EN.
module cpu_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [STATE_W-1:0]  state,
  output logic                rd,
  output logic                wr,
  output logic                load_ir,
  output logic                inc_pc,
  output logic                load_pc,
  output logic                load_acc,
  output logic                datactl_ena,
  output logic                halt
);

  state_e  state_q;
  strobe_t strobes_c;
  logic    run_c;

  // Strobes are silenced during reset; in step mode S0 only proceeds on a step.
`ifdef CPU_CTRL_SINGLE_STEP_EN
  assign run_c = rst_n && ena && ((state_q != S0) || step);
`else
  assign run_c = rst_n && ena;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else if (run_c) begin
      case (state_q)
        S3:      state_q <= (opcode == OP_HLT) ? HALTED : S4;
        S7:      state_q <= S0;
        HALTED:  state_q <= HALTED;
        default: state_q <= state_e'(state_q + STATE_W'(1));
      endcase
    end
  end

  cpu_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .ena       (run_c),
    .strobes_c (strobes_c)
  );

  assign state       = state_q;
  assign rd          = strobes_c.rd;
  assign wr          = strobes_c.wr;
  assign load_ir     = strobes_c.load_ir;
  assign inc_pc      = strobes_c.inc_pc;
  assign load_pc     = strobes_c.load_pc;
  assign load_acc    = strobes_c.load_acc;
  assign datactl_ena = strobes_c.datactl_ena;
  assign halt        = strobes_c.halt;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed instruction traces, randomized
// instruction/enable/zero streams against an instruction-level reference model.
module tb_cpu_ctrl_fsm;

  localparam logic [7:0] B_RD  = 8'h80;
  localparam logic [7:0] B_WR  = 8'h40;
  localparam logic [7:0] B_IR  = 8'h20;
  localparam logic [7:0] B_PC  = 8'h10;
  localparam logic [7:0] B_LPC = 8'h08;
  localparam logic [7:0] B_ACC = 8'h04;
  localparam logic [7:0] B_DB  = 8'h02;
  localparam logic [7:0] B_HLT = 8'h01;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n, ena, zero;
  logic [2:0] opcode;
  logic [3:0] state;
  logic       rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .state       (state),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  function automatic logic [7:0] strobes();
    return {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: what the datapath must see in phase ph of an instruction.
  function automatic logic [7:0] model(input int ph, input logic [2:0] op, input logic z);
    logic [7:0] v;
    logic acc_user;
    v = 8'h00;
    acc_user = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    if (ph == 0)                                v = B_RD | B_IR;
    else if (ph == 1)                           v = B_RD | B_IR | B_PC;
    else if (ph == 3)                           v = (op == HLT) ? B_HLT : B_PC;
    else if (op == STO && ph >= 4 && ph <= 6)   v = B_DB | ((ph == 5) ? B_WR : 8'h00);
    else if (acc_user && (ph == 4 || ph == 5))  v = B_RD | ((ph == 5) ? B_ACC : 8'h00);
    else if (op == JMP && (ph == 4 || ph == 5)) v = B_LPC;
    else if (op == SKZ && ph >= 6 && z)         v = B_PC;
    return v;
  endfunction

  // Runs phases 0..stop_ph-1 of one instruction; zmode 0/1 fixed zero, 2 random.
  task automatic run_instr(input string tag, input logic [2:0] op, input int ena_pct,
                           input int zmode, input int stall_ph, input int stop_ph);
    int ph, pcs, pc_exp, viol, stall_left, cycles;
    logic en;
    ph = 0; pcs = 0; pc_exp = 2; viol = 0; stall_left = 3; cycles = 0;
    while (ph < stop_ph && cycles < 100) begin
      cycles++;
      opcode = op;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (ph == stall_ph && stall_left > 0) begin
        en = 1'b0;
        stall_left--;
      end else begin
        en = ($urandom_range(0, 99) < ena_pct);
      end
      ena = en;
      @(negedge clk);
      check($sformatf("%s ph%0d ena%0d strobes", tag, ph, en), strobes(),
            en ? model(ph, op, zero) : 8'h00);
      check($sformatf("%s ph%0d state", tag, ph), {4'h0, state}, 8'(ph));
      if (inc_pc) pcs++;
      if (wr && !datactl_ena) viol++;
      if (en) begin
        if (op == SKZ && ph >= 6 && zero) pc_exp++;
        ph++;
      end
      @(posedge clk);
      #1;
    end
    if (stop_ph == 8) begin
      check($sformatf("%s end state", tag), {4'h0, state}, 8'h00);
      check($sformatf("%s inc_pc count", tag), 8'(pcs), 8'(pc_exp));
      check($sformatf("%s wr without bus", tag), 8'(viol), 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; opcode = LDA; zero = 1'b0;
    #12;
    check("reset state", {4'h0, state}, 8'h00);
    check("reset strobes", strobes(), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr("LDA", LDA, 100, 0, -1, 8);
    run_instr("STO", STO, 100, 0, -1, 8);
    run_instr("SKZ z1", SKZ, 100, 1, -1, 8);
    run_instr("SKZ z0", SKZ, 100, 0, -1, 8);
    run_instr("ADD stall", ADD, 100, 2, 4, 8);

    // Asynchronous reset in the middle of JMP's S5.
    run_instr("JMP pre", JMP, 100, 0, -1, 5);
    ena = 1'b1;
    #1;
    check("JMP S5 strobes", strobes(), B_LPC);
    #1;
    rst_n = 1'b0;
    #1;
    check("JMP async reset state", {4'h0, state}, 8'h00);
    check("JMP async reset strobes", strobes(), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("after reset LDA", LDA, 100, 2, -1, 8);

    repeat (40) run_instr("rand", 3'($urandom_range(1, 7)), 75, 2, -1, 8);

    // HLT: halt from S3, then frozen until reset.
    run_instr("HLT pre", HLT, 100, 2, -1, 3);
    ena = 1'b1;
    @(negedge clk);
    check("HLT S3 strobes", strobes(), B_HLT);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      ena = 1'($urandom_range(0, 1));
      opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("HALTED c%0d strobes", i), strobes(), B_HLT);
      check($sformatf("HALTED c%0d state", i), {4'h0, state}, 8'h08);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("HLT reset state", {4'h0, state}, 8'h00);
    check("HLT reset strobes", strobes(), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("post HLT XORR", XORR, 100, 2, -1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
